// File: rtl/div32s.sv
// div32s: iterative radix-2 restoring divider with uu/ss/su modes.
// One operation in flight; start/busy/done handshake, quotient/remainder held until next done.
module div32s #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic         busy,
    output logic         done,
    output logic         dbz
);

    localparam int unsigned CW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    quo;
    logic [W-1:0]    rem;
    logic [W-1:0]    divisor;
    logic [CW-1:0]   count;
    logic            sign_q;
    logic            sign_r;
    logic            dbz_pend;

    logic            is_ss;
    logic            is_su;
    logic            is_ovf;
    logic [W-1:0]    mag_a;
    logic [W-1:0]    mag_b;
    logic            nsign_q;
    logic            nsign_r;
    logic [W:0]      shifted;
    logic [W:0]      trial;

    // Operand magnitudes, result signs and one restoring-step trial subtraction
    always_comb begin
        is_ss   = (mode == 2'b01);
        is_su   = (mode == 2'b10);
        mag_a   = a;
        mag_b   = b;
        nsign_q = 1'b0;
        nsign_r = 1'b0;
        if ((is_ss || is_su) && a[W-1]) begin
            mag_a = -a;
        end
        if (is_ss && b[W-1]) begin
            mag_b = -b;
        end
        if (is_ss) begin
            nsign_q = a[W-1] ^ b[W-1];
            nsign_r = a[W-1];
        end else if (is_su) begin
            nsign_q = a[W-1];
            nsign_r = a[W-1];
        end
        is_ovf  = is_ss && (a == {1'b1, {(W-1){1'b0}}}) && (b == {W{1'b1}});
        shifted = {rem, quo[W-1]};
        trial   = shifted - {1'b0, divisor};
    end

    // Control FSM and datapath registers; special cases skip CALC and preload the result
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            quo      <= '0;
            rem      <= '0;
            divisor  <= '0;
            count    <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            dbz_pend <= 1'b0;
            q        <= '0;
            r        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dbz      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        count <= '0;
                        if (b == '0) begin
                            quo      <= {W{1'b1}};
                            rem      <= a;
                            sign_q   <= 1'b0;
                            sign_r   <= 1'b0;
                            dbz_pend <= 1'b1;
                            state    <= FIX;
                        end else if (is_ovf) begin
                            quo      <= {1'b1, {(W-1){1'b0}}};
                            rem      <= '0;
                            sign_q   <= 1'b0;
                            sign_r   <= 1'b0;
                            dbz_pend <= 1'b0;
                            state    <= FIX;
                        end else begin
                            quo      <= mag_a;
                            rem      <= '0;
                            divisor  <= mag_b;
                            sign_q   <= nsign_q;
                            sign_r   <= nsign_r;
                            dbz_pend <= 1'b0;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    quo <= {quo[W-2:0], ~trial[W]};
                    rem <= trial[W] ? shifted[W-1:0] : trial[W-1:0];
                    count <= count + CW'(1);
                    if (count == CW'(W - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    q     <= sign_q ? -quo : quo;
                    r     <= sign_r ? -rem : rem;
                    dbz   <= dbz_pend;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
